// File: rtl/rv32i_decode.sv
// rv32i_decode: RV32I decode stage between fetch and the ALU.
// It drives the register-file read indices and registers the decoded fields for one cycle.
module rv32i_decode #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic        hazard,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [4:0]  d_rd_idx,
  output logic [31:0] d_imm,
  output logic [6:0]  d_opcode,
  output logic [2:0]  d_funct3,
  output logic        d_funct7b5,
  output logic        d_is_load,
  output logic        d_is_store,
  output logic        d_illegal
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic        take;
  logic        bubble;
  logic [4:0]  hold_rs1;
  logic [4:0]  hold_rs2;

  logic [6:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        f_r;
  logic        f_i;
  logic        f_s;
  logic        f_b;
  logic        f_u;
  logic        f_j;
  logic        f_n;
  logic        bad;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        src_hit;

  assign op  = instr[6:0];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  always_comb begin
    f_r = 1'b0;
    f_i = 1'b0;
    f_s = 1'b0;
    f_b = 1'b0;
    f_u = 1'b0;
    f_j = 1'b0;
    f_n = 1'b0;
    bad = 1'b0;
    unique case (1'b1)
      op == OP_OP:     f_r = 1'b1;
      op == OP_LOAD,
      op == OP_IMM,
      op == OP_JALR:   f_i = 1'b1;
      op == OP_STORE:  f_s = 1'b1;
      op == OP_BRANCH: f_b = 1'b1;
      op == OP_LUI,
      op == OP_AUIPC:  f_u = 1'b1;
      op == OP_JAL:    f_j = 1'b1;
      op == OP_FENCE,
      op == OP_SYSTEM: f_n = 1'b1;
      default:         bad = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (1'b1)
      f_i: imm = {{20{instr[31]}}, instr[31:20]};
      f_s: imm = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
      f_b: imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
      f_u: imm = {instr[31:12], 12'h000};
      f_j: imm = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Illegal encodings carry no destination but still name rs1.
  assign rd = (f_r | f_i | f_u | f_j | f_n)
            ? instr[11:7] : 5'd0;
  assign use_rs1 = ~(f_u | f_j);
  assign use_rs2 = f_r | f_s | f_b;
  assign src_hit = (use_rs1 & (d_rd_idx == rs1))
                 | (use_rs2 & (d_rd_idx == rs2));

  assign hazard = d_valid & d_is_load
                & (d_rd_idx != 5'd0)
                & instr_valid & ~stall & ~flush
                & (state_q == RUN) & src_hit;

  assign rs1_idx = stall ? hold_rs1 : rs1;
  assign rs2_idx = stall ? hold_rs2 : rs2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    bubble  = 1'b0;
    if (!stall) begin
      if (flush) begin
        state_d = DRAIN;
        cnt_d   = FC;
        bubble  = 1'b1;
      end else if (state_q == DRAIN) begin
        bubble = 1'b1;
        if (instr_valid) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
      end else if (hazard || !instr_valid) begin
        bubble = 1'b1;
      end else begin
        take = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      d_valid    <= 1'b0;
      d_pc       <= '0;
      d_rd_idx   <= '0;
      d_imm      <= '0;
      d_opcode   <= NOP_INSTR[6:0];
      d_funct3   <= NOP_INSTR[14:12];
      d_funct7b5 <= NOP_INSTR[30];
      d_is_load  <= 1'b0;
      d_is_store <= 1'b0;
      d_illegal  <= 1'b0;
      hold_rs1   <= NOP_INSTR[19:15];
      hold_rs2   <= NOP_INSTR[24:20];
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        d_valid    <= 1'b1;
        d_pc       <= instr_pc;
        d_rd_idx   <= rd;
        d_imm      <= imm;
        d_opcode   <= op;
        d_funct3   <= instr[14:12];
        d_funct7b5 <= instr[30];
        d_is_load  <= (op == OP_LOAD);
        d_is_store <= (op == OP_STORE);
        d_illegal  <= bad;
        hold_rs1   <= rs1;
        hold_rs2   <= rs2;
      end else if (bubble) begin
        d_valid    <= 1'b0;
        d_pc       <= '0;
        d_rd_idx   <= '0;
        d_imm      <= '0;
        d_opcode   <= NOP_INSTR[6:0];
        d_funct3   <= NOP_INSTR[14:12];
        d_funct7b5 <= NOP_INSTR[30];
        d_is_load  <= 1'b0;
        d_is_store <= 1'b0;
        d_illegal  <= 1'b0;
        hold_rs1   <= NOP_INSTR[19:15];
        hold_rs2   <= NOP_INSTR[24:20];
      end
    end
  end
endmodule

// File: doc/rv32i_decode.md
Name: rv32i_decode

Overview:
- Single-HART RV32I decode stage, directly upstream of the register file.
- Takes the fetched instruction and its PC.
- Drives the register-file read indices in the same cycle as the instruction arrives.
- Registers the decoded fields for one cycle, so they reach the ALU aligned with the rs1/rs2 values the register file returns.
- Also detects load-use hazards and squashes instructions after a taken branch or jump.

Parameters:
- FLUSH_CYCLES, 2, number of instr_valid beats dropped after a flush; covers the fetch pipeline depth. Legal range 1–3.
- NOP_INSTR, 32'h00000013, encoding loaded into the decode register on reset and on bubbles.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- instr  in  32  fetched instruction
- instr_pc  in  32  address of instr
- instr_valid  in  1  instr/instr_pc valid this cycle
- stall  in  1  downstream (memory) stall; freezes this stage
- flush  in  1  taken branch/jump at ALU (same signal as the register file's update_pc)
- rs1_idx  out  5  register-file rs1 read index (combinational)
- rs2_idx  out  5  register-file rs2 read index (combinational)
- hazard  out  1  load-use stall request to fetch; fetch holds instr/instr_pc while high
- d_valid  out  1  decoded instruction valid
- d_pc  out  32  PC of decoded instruction
- d_rd_idx  out  5  destination index; forced to 0 when the format has no rd
- d_imm  out  32  sign-extended immediate
- d_opcode  out  7  instr[6:0]
- d_funct3  out  3  instr[14:12]
- d_funct7b5  out  1  instr[30]
- d_is_load  out  1  opcode 0000011
- d_is_store  out  1  opcode 0100011
- d_illegal  out  1  undecodable instruction

Interface:
- One clock, clk. Reset is asynchronous and active-low, reset_n. Polarity and synchronicity are fixed.

Behaviour:
- Reset (async assert, sync release), all registered outputs:
  - d_valid=0, d_pc=0, d_rd_idx=0, d_imm=0.
  - d_opcode/d_funct3/d_funct7b5 take the fields of NOP_INSTR.
  - d_is_load=0, d_is_store=0, d_illegal=0.
  - Flush counter=0, FSM=RUN.
- Reset asserted mid-operation discards everything in flight. The first instruction is accepted on the first cycle after release.
- Index mux:
  - stall=1: rs1_idx/rs2_idx = indices of the instruction held in the decode register, so the register file re-reads the held operands.
  - Otherwise: rs1_idx = instr[19:15], rs2_idx = instr[24:20].
  - Indices are driven regardless of instr_valid.
- Latency: one cycle. An instruction presented at edge N appears on d_* after edge N, coincident with the register file's rs1/rs2 for the same indices.
- Immediates, all sign-extended from instr[31]:
  - I: loads, OP-IMM, JALR.
  - S: stores.
  - B: branches, bit0=0.
  - U: LUI/AUIPC, low 12 bits=0.
  - J: JAL, bit0=0.
  - d_imm=0 for R-type and SYSTEM/FENCE.
- d_rd_idx = instr[11:7] for R/I/U/J; 0 for S/B.
- d_illegal=1 if:
  - instr[1:0]!=2'b11, or
  - opcode is not one of the 11 RV32I major opcodes.
  - An illegal instruction is still passed with d_valid=1 and d_rd_idx forced to 0.
- Load-use hazard:
  - hazard=1 when d_valid & d_is_load & d_rd_idx!=0 & instr_valid & ~stall & FSM=RUN, and d_rd_idx matches a source register of instr:
    - rs1 for all formats except U/J;
    - rs2 only for R/S/B.
  - On a hazard cycle: the decode register loads a bubble (d_valid=0, fields of NOP_INSTR) and instr is not consumed.
  - Fetch re-presents the same instr next cycle; it decodes normally then. Exactly one bubble per hazard.
- stall=1: all d_* registers and FSM hold; hazard=0.
- FSM:
  - RUN: instr_valid loads the decode register; instr_valid=0 loads a bubble.
  - flush=1 → DRAIN: decode register loads a bubble, counter=FLUSH_CYCLES.
  - DRAIN: each instr_valid beat is dropped (bubble) and decrements the counter. Counter reaching 0 → RUN; the next valid beat is accepted.
  - flush in DRAIN reloads the counter to FLUSH_CYCLES.
- Priority, highest first: reset, stall, flush, hazard, normal load.
  - flush together with hazard: the flush wins and hazard=0.
  - flush during stall is ignored; the upstream holds flush until stall drops.

Test Plan:
1. Reset, then instr=0x00500093 (addi x1,x0,5) @pc 0x0 → same cycle rs1_idx=0. Next cycle d_valid=1, d_rd_idx=1, d_imm=5, d_opcode=0x13, d_illegal=0.
2. instr=0xFE000EE3 (beq x0,x0,-4) → d_imm=0xFFFFFFFC, d_rd_idx=0. instr=0x123450B7 (lui x1) → d_imm=0x12345000.
3. lw x5,0(x2)=0x00012283, then add x6,x5,x1=0x00128333:
   - hazard=1 for one cycle; d_valid=0 in the following cycle; then the add appears with d_rd_idx=6.
   - Repeat with lw rd=x0 → no hazard.
4. flush=1 with FLUSH_CYCLES=2 and a back-to-back valid stream → exactly 2 beats dropped (d_valid=0); the third beat decoded. A second flush during DRAIN restarts the drop count.
5. stall=1 for 3 cycles holding the add → d_* unchanged, rs1_idx=5/rs2_idx=1 throughout, hazard=0. Resume → next instr accepted.
6. instr=0x00000000 → d_illegal=1, d_rd_idx=0. Assert reset_n low mid-stream → d_valid=0 immediately, without waiting for a clk edge.
